pipe_hazard_ctrl: RTL

- Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Generates per-stage enable (hold) and flush (bubble) controls and EX-stage forwarding selects.
- Covers three cases: load-use hazards, taken-branch redirects and data-memory wait handshakes.
- Contains a memory-wait FSM with timeout fault, plus saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central sequencer for the IF_ID / ID_EX / EX_MEM / MEM_WB pipeline
// registers of a 5-stage pipeline. It produces per-stage hold (enable) and
// bubble (flush) controls, the PC load enable and redirect select, and the
// EX-stage operand forwarding selects.
//
// Handled situations, in priority order:
//   - memory timeout fault  : whole pipeline frozen until fault_clr
//   - data-memory wait      : everything upstream of MEM_WB frozen, bubble to WB
//   - taken branch in EX    : redirect PC, squash IF_ID and ID_EX
//   - load-use hazard       : hold PC and IF_ID, bubble into ID_EX
//
// Parameters:
//   MEM_TIMEOUT  consecutive dmem wait cycles before FAULT (valid 2..255)
//   CNT_W        width of the saturating performance counters
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   id_rs1/id_rs2, id_use_rs1/2    source registers of the ID instruction
//   ex_rs1/ex_rs2, ex_Rd           registers of the EX instruction
//   ex_memread, ex_regwrite        EX instruction is a load / writes Rd
//   ex_branch_taken                branch/jump in EX resolved taken
//   mem_Rd, mem_regwrite           destination of the MEM instruction
//   mem_req, dmem_ready            data-memory request / completion
//   wb_Rd, wb_regwrite             destination of the WB instruction
//   fault_clr                      leave the FAULT state
//   pc_en, redirect                PC load enable / branch-target select
//   *_en, *_flush                  stage register enable / bubble load
//   fwd_a, fwd_b                   EX operand select: 00 RF, 01 WB, 10 MEM
//   mem_fault                      sticky memory timeout fault
//   stall_cnt, flush_cnt           saturating counts of pc_en=0 / redirect
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,

    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_Rd,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic             ex_branch_taken,

    input  logic [4:0]       mem_Rd,
    input  logic             mem_regwrite,
    input  logic             mem_req,
    input  logic             dmem_ready,

    input  logic [4:0]       wb_Rd,
    input  logic             wb_regwrite,

    input  logic             fault_clr,

    output logic             pc_en,
    output logic             redirect,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // FSM encoding kept as plain constants for compatibility with the
    // existing netlist-level debug scripts.
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_fault;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [1:0]       w_state_nxt;
    logic [7:0]       w_wait_nxt;
    logic             w_fault_nxt;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    logic w_in_fault;
    logic w_mem_stall;
    logic w_load_use;

    assign w_in_fault  = (r_state == ST_FAULT);
    // A frozen pipeline in FAULT does not react to the memory handshake.
    assign w_mem_stall = ~w_in_fault & mem_req & ~dmem_ready;

    assign w_load_use = ex_memread & ex_regwrite & (ex_Rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_Rd)) |
                         (id_use_rs2 & (id_rs2 == ex_Rd)));

    // -----------------------------------------------------------------------
    // Memory-wait FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_fault_nxt = r_mem_fault;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (!w_mem_stall) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = 8'd0;
                end else begin
                    w_wait_nxt = r_wait_cnt + 8'd1;
                    if ((r_wait_cnt + 8'd1) == TIMEOUT_C) begin
                        w_state_nxt = ST_FAULT;
                        w_fault_nxt = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = 8'd0;
                    w_fault_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = 8'd0;
                w_fault_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 8'd0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_mem_fault <= w_fault_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline controls (priority chain)
    // -----------------------------------------------------------------------
    logic w_pc_en;
    logic w_redirect;
    logic w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic w_if_id_fl, w_id_ex_fl, w_ex_mem_fl, w_mem_wb_fl;

    always_comb begin
        w_pc_en     = 1'b1;
        w_redirect  = 1'b0;
        w_if_id_en  = 1'b1;
        w_id_ex_en  = 1'b1;
        w_ex_mem_en = 1'b1;
        w_mem_wb_en = 1'b1;
        w_if_id_fl  = 1'b0;
        w_id_ex_fl  = 1'b0;
        w_ex_mem_fl = 1'b0;
        w_mem_wb_fl = 1'b0;

        if (rst) begin
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_en = 1'b0;
            w_if_id_fl  = 1'b1;
            w_id_ex_fl  = 1'b1;
            w_ex_mem_fl = 1'b1;
            w_mem_wb_fl = 1'b1;
        end else if (w_in_fault) begin
            // Frozen; the clearing cycle raises every flush so the pipeline
            // restarts from bubbles.
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_en = 1'b0;
            w_if_id_fl  = fault_clr;
            w_id_ex_fl  = fault_clr;
            w_ex_mem_fl = fault_clr;
            w_mem_wb_fl = fault_clr;
        end else if (w_mem_stall) begin
            // A taken branch stays parked in the frozen EX stage and
            // redirects once the memory access completes.
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_fl = 1'b1;
        end else if (ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use on it is moot.
            w_redirect = 1'b1;
            w_if_id_fl = 1'b1;
            w_id_ex_fl = 1'b1;
        end else if (w_load_use) begin
            w_pc_en    = 1'b0;
            w_if_id_en = 1'b0;
            w_id_ex_fl = 1'b1;
        end
    end

    assign pc_en        = w_pc_en;
    assign redirect     = w_redirect;
    assign if_id_en     = w_if_id_en;
    assign id_ex_en     = w_id_ex_en;
    assign ex_mem_en    = w_ex_mem_en;
    assign mem_wb_en    = w_mem_wb_en;
    assign if_id_flush  = w_if_id_fl;
    assign id_ex_flush  = w_id_ex_fl;
    assign ex_mem_flush = w_ex_mem_fl;
    assign mem_wb_flush = w_mem_wb_fl;

    // -----------------------------------------------------------------------
    // Forwarding: youngest producer (MEM) wins over WB; x0 never forwards.
    // -----------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs))
            return FWD_MEM;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_fwd_a = rst ? FWD_RF : fwd_sel(ex_rs1, mem_Rd, mem_regwrite, wb_Rd, wb_regwrite);
    assign w_fwd_b = rst ? FWD_RF : fwd_sel(ex_rs2, mem_Rd, mem_regwrite, wb_Rd, wb_regwrite);

    assign fwd_a = w_fwd_a;
    assign fwd_b = w_fwd_b;

    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_redirect && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign mem_fault = r_mem_fault;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
